cache_victim_policy: RTL
========================

// Module: cache_victim_policy
// PURPOSE
//   Parametrised per-set cache replacement engine for the I$/D$ way-select path. Picks the
//   one-hot victim way on a miss fill and tracks per-set replacement state. POLICY selects tree
//   pseudo-LRU, LFSR random, or per-set round-robin. Invalid ways are always filled first.
// PARAMETERS
//   NUMWAYS   4    ways per set; power of 2, 1..64
//   SETLEN    7    set-index width
//   NUMSETS   128  sets; must equal 2**SETLEN
//   POLICY    0    0 = tree PLRU, 1 = LFSR random, 2 = round-robin; other values are illegal (elab error)
//   LFSRWIDTH LOGNUMWAYS+2  LFSR width; supported 3..9; LOGNUMWAYS = $clog2(NUMWAYS)
// PORTS
//   clk             in   1           clock; all state updates on the rising edge
//   reset           in   1           synchronous, active-high
//   FlushStage      in   1           squashes the update in the current cycle
//   CacheEn         in   1           enables the state read; 0 holds CurrState
//   HitWay          in   NUMWAYS     one-hot hit way; 0 = miss
//   ValidWay        in   NUMWAYS     valid bits of the addressed set
//   CacheSetData    in   SETLEN      set index for the next-cycle state read
//   CacheSetTag     in   SETLEN      set index of the current access; the update target
//   LRUWriteEn      in   1           commits the access to the replacement state
//   InvalidateCache in   1           clears all per-set state
//   VictimWay       out  NUMWAYS     one-hot victim for the current access
// BEHAVIOUR
//   - Storage: a flop array of NUMSETS entries, STW bits each.
//     - STW = NUMWAYS-1 for PLRU, LOGNUMWAYS for round-robin, 0 for LFSR (one global LFSR).
//   - Read: CurrState <= State[CacheSetData] when CacheEn=1, one-cycle latency; held when CacheEn=0.
//     - Write-first bypass: if an update to CacheSetTag commits in the same cycle and
//       CacheSetTag == CacheSetData, CurrState takes the new value.
//   - Victim (combinational from CurrState, ValidWay, LFSR):
//     - If ~&ValidWay: the lowest-index invalid way.
//     - PLRU: walk the tree from the root; bit=0 goes left (lower ways), 1 goes right.
//     - LFSR: way = lfsr[LOGNUMWAYS-1:0].
//     - Round-robin: way = CurrState.
//   - Update: Upd = LRUWriteEn & ~FlushStage. UsedWay = HitWay if |HitWay, else VictimWay.
//     - PLRU: on hit or miss, set each tree node on UsedWay's path to point away from UsedWay.
//     - Round-robin: on a miss with all ways valid, State[CacheSetTag] <= way+1 mod NUMWAYS.
//       A hit or an invalid-way fill leaves the state unchanged.
//     - LFSR: advances one step (Fibonacci, shift right, maximal taps) only on a miss with all
//       ways valid; hits never advance it.
//   - reset (and InvalidateCache, which does not affect the LFSR):
//     - all State = 0, CurrState = 0;
//     - LFSR = {0..0,1} (reset only); the LFSR never reaches all-zero.
//     - Result: VictimWay = 0...01 while ValidWay = 0.
//   - InvalidateCache takes priority over a same-cycle Upd; the update is dropped.
//   - NUMWAYS=1: VictimWay is constant 1; no state.
//   - Multi-hot HitWay is illegal; an assertion fires and the update result is undefined.
//   - Mid-operation reset discards the pending update; no partial state update.
// TESTING
//   - Reset, ValidWay=4'b0000 -> VictimWay=4'b0001; ValidWay=4'b1011 -> 4'b0100.
//   - PLRU, 4 ways, set 5 all valid: hits on ways 0,1,2,3 in order -> next VictimWay=4'b0001;
//     hit 0 then hit 2 -> VictimWay=4'b0010.
//   - Round-robin, all valid: 5 miss fills on set 3 -> victims 0,1,2,3,0. Set 4 is unaffected (victim 0).
//   - LFSR, NUMWAYS=4 (width 4): 15 all-valid misses -> LFSR period 15, no zero state;
//     interleaved hits leave the sequence unchanged.
//   - Bypass: update set 9 with CacheSetData=9 in the same cycle -> next-cycle victim reflects the new state.
//     FlushStage=1 -> state unchanged.
//   - InvalidateCache with a concurrent Upd -> all sets read 0; the LFSR value is preserved.

Source files
------------

// File: rtl/cache_victim_policy.sv
// Per-set cache replacement engine: tree PLRU, LFSR random or round-robin victim selection,
// invalid ways filled first, registered state read with a write-first bypass.

module cache_victim_policy_chk #(
  parameter int NUMWAYS = 4
) (
  input logic               clk,
  input logic               reset,
  input logic               LRUWriteEn,
  input logic               FlushStage,
  input logic [NUMWAYS-1:0] HitWay
);
  // A committed access must carry at most one hit way
  property pHitOneHot;
    @(posedge clk) disable iff (reset) (LRUWriteEn && !FlushStage) |-> $onehot0(HitWay);
  endproperty
  aHitOneHot: assert property (pHitOneHot);
endmodule

module cache_victim_policy #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 7,
  parameter int NUMSETS   = 128,
  parameter int POLICY    = 0,
  parameter int LFSRWIDTH = $clog2(NUMWAYS) + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStage,
  input  logic               CacheEn,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [SETLEN-1:0]  CacheSetData,
  input  logic [SETLEN-1:0]  CacheSetTag,
  input  logic               LRUWriteEn,
  input  logic               InvalidateCache,
  output logic [NUMWAYS-1:0] VictimWay
);
  localparam int LOGNUMWAYS = $clog2(NUMWAYS);
  localparam int LW = (LOGNUMWAYS > 0) ? LOGNUMWAYS : 1;

  function automatic logic [8:0] lfsrTaps(input int width);
    logic [8:0] taps;
    case (width)
      3:       taps = 9'b000000011;
      4:       taps = 9'b000000011;
      5:       taps = 9'b000000101;
      6:       taps = 9'b000000011;
      7:       taps = 9'b000000011;
      8:       taps = 9'b000011101;
      9:       taps = 9'b000010001;
      default: taps = 9'b000000011;
    endcase
    return taps;
  endfunction

  if (POLICY < 0 || POLICY > 2) begin : gBadPolicy
    $error("cache_victim_policy: POLICY must be 0, 1 or 2");
  end
  if (NUMWAYS < 1 || NUMWAYS > 64 || (NUMWAYS & (NUMWAYS - 1)) != 0) begin : gBadWays
    $error("cache_victim_policy: NUMWAYS must be a power of 2 in 1..64");
  end
  if (NUMSETS != (1 << SETLEN)) begin : gBadSets
    $error("cache_victim_policy: NUMSETS must equal 2**SETLEN");
  end

  cache_victim_policy_chk #(.NUMWAYS(NUMWAYS)) uChk (
    .clk        (clk),
    .reset      (reset),
    .LRUWriteEn (LRUWriteEn),
    .FlushStage (FlushStage),
    .HitWay     (HitWay)
  );

  if (NUMWAYS == 1) begin : gSingle
    logic unusedIns;
    assign unusedIns = ^{clk, reset, FlushStage, CacheEn, HitWay, ValidWay, CacheSetData,
                         CacheSetTag, LRUWriteEn, InvalidateCache};
    assign VictimWay = {NUMWAYS{1'b1}};
  end else begin : gMulti
    logic          upd;
    logic          allValid;
    logic          missFill;
    logic [LW-1:0] fillIdx;
    logic [LW-1:0] policyIdx;
    logic [LW-1:0] victimIdx;

    if (LFSRWIDTH < 3 || LFSRWIDTH > 9 || LFSRWIDTH < LOGNUMWAYS) begin : gBadLfsr
      $error("cache_victim_policy: LFSRWIDTH must be in 3..9 and cover the way index");
    end

    // Lowest invalid way wins over the policy choice
    always_comb begin
      fillIdx = {LW{1'b0}};
      for (int w = NUMWAYS - 1; w >= 0; w--) begin
        fillIdx = ValidWay[w] ? fillIdx : LW'(w);
      end
      allValid  = &ValidWay;
      victimIdx = allValid ? policyIdx : fillIdx;
      upd       = LRUWriteEn & ~FlushStage;
      missFill  = upd & ~(|HitWay) & allValid;
    end

    assign VictimWay = NUMWAYS'(1'b1) << victimIdx;

    if (POLICY == 1) begin : gLfsr
      localparam logic [8:0] TAPS = lfsrTaps(LFSRWIDTH);
      logic [LFSRWIDTH-1:0] lfsr;
      logic                 unusedIns;

      assign unusedIns = ^{CacheEn, CacheSetData, CacheSetTag};
      assign policyIdx = lfsr[LW-1:0];

      // Global LFSR steps only on a replacing miss; invalidation leaves it alone
      always_ff @(posedge clk) begin
        if (reset) begin
          lfsr <= {{(LFSRWIDTH-1){1'b0}}, 1'b1};
        end else if (missFill && !InvalidateCache) begin
          lfsr <= {^(lfsr & TAPS[LFSRWIDTH-1:0]), lfsr[LFSRWIDTH-1:1]};
        end
      end
    end else begin : gState
      localparam int STW = (POLICY == 0) ? NUMWAYS - 1 : LOGNUMWAYS;
      logic [STW-1:0] stateMem [NUMSETS];
      logic [STW-1:0] currState;
      logic [STW-1:0] newState;
      logic           wrEn;

      if (POLICY == 0) begin : gPlru
        logic [NUMWAYS-1:0] match;
        logic [LW-1:0]      hitIdx;
        logic [LW-1:0]      usedIdx;

        // Victim is the one leaf whose whole root path points toward it
        always_comb begin
          match     = {NUMWAYS{1'b1}};
          policyIdx = {LW{1'b0}};
          for (int l = 0; l < LOGNUMWAYS; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
              for (int w = 0; w < NUMWAYS; w++) begin
                match[w] = match[w] & (((w >> (LOGNUMWAYS - l)) != p) ||
                           (currState[(1 << l) - 1 + p] == 1'((w >> (LOGNUMWAYS - 1 - l)) & 1)));
              end
            end
          end
          for (int w = 0; w < NUMWAYS; w++) begin
            policyIdx = policyIdx | (match[w] ? LW'(w) : {LW{1'b0}});
          end
        end

        // Nodes on the used way's path are turned to point away from it
        always_comb begin
          hitIdx = {LW{1'b0}};
          for (int w = 0; w < NUMWAYS; w++) begin
            hitIdx = hitIdx | (HitWay[w] ? LW'(w) : {LW{1'b0}});
          end
          usedIdx  = (|HitWay) ? hitIdx : victimIdx;
          newState = currState;
          for (int l = 0; l < LOGNUMWAYS; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
              if ((int'(usedIdx) >> (LOGNUMWAYS - l)) == p) begin
                newState[(1 << l) - 1 + p] = ~usedIdx[LOGNUMWAYS - 1 - l];
              end else begin
                newState[(1 << l) - 1 + p] = currState[(1 << l) - 1 + p];
              end
            end
          end
          wrEn = upd;
        end
      end else begin : gRr
        assign policyIdx = currState;
        assign newState  = currState + LW'(1'b1);
        assign wrEn      = missFill;
      end

      // Per-set state array and its registered read; invalidation beats any update
      always_ff @(posedge clk) begin
        if (reset || InvalidateCache) begin
          for (int s = 0; s < NUMSETS; s++) begin
            stateMem[s] <= {STW{1'b0}};
          end
          currState <= {STW{1'b0}};
        end else begin
          if (wrEn) begin
            stateMem[CacheSetTag] <= newState;
          end
          if (CacheEn) begin
            currState <= (wrEn && (CacheSetTag == CacheSetData)) ? newState
                                                                  : stateMem[CacheSetData];
          end
        end
      end
    end
  end
endmodule
